// File: rtl/wb_ctrl.sv
// Register-file writeback controller: zero sweep after reset, ALU/load-response
// arbitration onto a single write port, and a per-register outstanding-load scoreboard.
module wb_ctrl #(
   parameter  int unsigned WIDTH_ADDR = 5,
   parameter  int unsigned WIDTH_DATA = 32,
   localparam int unsigned NREG       = 2 ** WIDTH_ADDR
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_wb_en,
   input  logic [WIDTH_ADDR-1:0] alu_wb_addr,
   input  logic [WIDTH_DATA-1:0] alu_wb_data,
   input  logic                  ld_issue_en,
   input  logic [WIDTH_ADDR-1:0] ld_issue_addr,
   input  logic                  ld_rsp_valid,
   output logic                  ld_rsp_ready,
   input  logic [WIDTH_ADDR-1:0] ld_rsp_addr,
   input  logic [WIDTH_DATA-1:0] ld_rsp_data,
   output logic                  wr_en,
   output logic [WIDTH_ADDR-1:0] wr_addr,
   output logic [WIDTH_DATA-1:0] wr_data,
   output logic [NREG-1:0]       busy,
   output logic                  init_done
);

   typedef enum logic {
      S_INIT,
      S_RUN
   } state_t;

   state_t                state_q, state_d;
   logic [WIDTH_ADDR-1:0] cnt_q, cnt_d;
   logic                  init_done_q, init_done_d;
   logic                  wr_en_q, wr_en_d;
   logic [WIDTH_ADDR-1:0] wr_addr_q, wr_addr_d;
   logic [WIDTH_DATA-1:0] wr_data_q, wr_data_d;
   logic [NREG-1:0]       busy_q, busy_d;

   logic [WIDTH_ADDR-1:0] fa_q [2];
   logic [WIDTH_ADDR-1:0] fa_d [2];
   logic [WIDTH_DATA-1:0] fd_q [2];
   logic [WIDTH_DATA-1:0] fd_d [2];
   logic                  rd_ptr_q, rd_ptr_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic [1:0]            count_q, count_d;

   logic                  ready;
   logic                  alu_ok;
   logic                  push;
   logic                  pop;

   assign ready        = init_done_q && (count_q < 2'd2);
   assign ld_rsp_ready = ready;
   assign wr_en        = wr_en_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign busy         = busy_q;
   assign init_done    = init_done_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_done_d = init_done_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      busy_d      = busy_q;
      fa_d        = fa_q;
      fd_d        = fd_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      push        = 1'b0;
      pop         = 1'b0;
      alu_ok      = alu_wb_en && (alu_wb_addr != '0);

      case (state_q)
         S_INIT: begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
            wr_data_d = '0;
            cnt_d     = cnt_q + WIDTH_ADDR'(1);
            if (cnt_q == '1) state_d = S_RUN;
         end
         S_RUN: begin
            // First RUN cycle only publishes init_done; arbitration starts once it is visible.
            if (!init_done_q) begin
               init_done_d = 1'b1;
            end else begin
               if (alu_ok) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = alu_wb_addr;
                  wr_data_d = alu_wb_data;
               end else if (count_q != 2'd0) begin
                  pop                    = 1'b1;
                  wr_en_d                = 1'b1;
                  wr_addr_d              = fa_q[rd_ptr_q];
                  wr_data_d              = fd_q[rd_ptr_q];
                  busy_d[fa_q[rd_ptr_q]] = 1'b0;
                  rd_ptr_d               = ~rd_ptr_q;
               end
               // Applied after the clear so a same-cycle issue keeps the bit set.
               if (ld_issue_en && (ld_issue_addr != '0)) busy_d[ld_issue_addr] = 1'b1;

               push = ld_rsp_valid && ready && (ld_rsp_addr != '0);
               if (push) begin
                  fa_d[wr_ptr_q] = ld_rsp_addr;
                  fd_d[wr_ptr_q] = ld_rsp_data;
                  wr_ptr_d       = ~wr_ptr_q;
               end
               count_d = count_q + 2'(push) - 2'(pop);
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_INIT;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         busy_q      <= '0;
         fa_q        <= '{default: '0};
         fd_q        <= '{default: '0};
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_q <= init_done_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         busy_q      <= busy_d;
         fa_q        <= fa_d;
         fd_q        <= fd_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
      end
   end

endmodule

// File: tb/tb_wb_ctrl.sv
// Bench for wb_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_wb_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        alu_wb_en = 1'b0;
   logic [4:0]  alu_wb_addr = '0;
   logic [31:0] alu_wb_data = '0;
   logic        ld_issue_en = 1'b0;
   logic [4:0]  ld_issue_addr = '0;
   logic        ld_rsp_valid = 1'b0;
   logic        ld_rsp_ready;
   logic [4:0]  ld_rsp_addr = '0;
   logic [31:0] ld_rsp_data = '0;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [31:0] busy;
   logic        init_done;

   int total = 0;
   int bad   = 0;

   wb_ctrl #(.WIDTH_ADDR(5), .WIDTH_DATA(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_wb_en(alu_wb_en), .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
      .ld_issue_en(ld_issue_en), .ld_issue_addr(ld_issue_addr),
      .ld_rsp_valid(ld_rsp_valid), .ld_rsp_ready(ld_rsp_ready),
      .ld_rsp_addr(ld_rsp_addr), .ld_rsp_data(ld_rsp_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .init_done(init_done)
   );

   always #5 clk = ~clk;

   // Reference model: pending load responses as a queue, busy as a bit vector.
   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        m_q[$];
   logic [31:0] m_busy = '0;
   logic        m_wr_en = 1'b0;
   logic [4:0]  m_wr_addr = '0;
   logic [31:0] m_wr_data = '0;
   logic        m_done = 1'b0;
   logic        m_ready = 1'b0;
   int          m_sweep = 0;

   task automatic model_update();
      bit   rdy;
      ent_t e;
      if (!rst_n) begin
         m_wr_en = 0; m_wr_addr = '0; m_wr_data = '0;
         m_busy = '0; m_done = 0; m_sweep = 0;
         m_q.delete();
      end else if (m_sweep < 32) begin
         m_wr_en = 1; m_wr_addr = m_sweep[4:0]; m_wr_data = '0;
         m_sweep++;
      end else if (!m_done) begin
         m_done = 1; m_wr_en = 0;
      end else begin
         rdy = (m_q.size() < 2);
         if (alu_wb_en && alu_wb_addr != 0) begin
            m_wr_en = 1; m_wr_addr = alu_wb_addr; m_wr_data = alu_wb_data;
         end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_wr_en = 1; m_wr_addr = e.a; m_wr_data = e.d;
            m_busy[e.a] = 1'b0;
         end else begin
            m_wr_en = 0;
         end
         if (ld_issue_en && ld_issue_addr != 0) m_busy[ld_issue_addr] = 1'b1;
         if (ld_rsp_valid && rdy && ld_rsp_addr != 0) begin
            e.a = ld_rsp_addr; e.d = ld_rsp_data;
            m_q.push_back(e);
         end
      end
      m_ready = m_done && (m_q.size() < 2);
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_wb_en = 0; ld_issue_en = 0; ld_rsp_valid = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle_inputs();
      step();
      step();
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
      total++; if (wr_addr !== 5'd0 || wr_data !== 32'd0) begin bad++; $display("FAIL reset_wr_addr_data got=%h/%h exp=0/0", wr_addr, wr_data); end
      total++; if (busy !== 32'd0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy); end
      total++; if (init_done !== 1'b0 || ld_rsp_ready !== 1'b0) begin bad++; $display("FAIL reset_done_ready got=%b%b exp=00", init_done, ld_rsp_ready); end
   endtask

   task automatic test_init();
      int errs = 0;
      rst_n = 1;
      alu_wb_en = 1; alu_wb_addr = 5'd6; alu_wb_data = 32'h5555_AAAA;
      ld_rsp_valid = 1; ld_rsp_addr = 5'd8; ld_issue_en = 1; ld_issue_addr = 5'd8;
      for (int i = 0; i < 32; i++) begin
         step();
         total++;
         if (wr_en !== 1'b1 || wr_addr !== 5'(i) || wr_data !== 32'd0 || init_done !== 1'b0 || ld_rsp_ready !== 1'b0) begin
            bad++;
            $display("FAIL init_sweep[%0d] got en=%b addr=%0d data=%h done=%b rdy=%b exp en=1 addr=%0d data=0 done=0 rdy=0",
                     i, wr_en, wr_addr, wr_data, init_done, ld_rsp_ready, i);
         end
      end
      idle_inputs();
      step();
      total++; if (init_done !== 1'b1 || ld_rsp_ready !== 1'b1) begin bad++; $display("FAIL init_done_rise got=%b%b exp=11", init_done, ld_rsp_ready); end
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL init_wr_off got=%b exp=0", wr_en); end
      total++; if (busy !== 32'd0) begin bad++; $display("FAIL init_busy_ignored got=%h exp=0", busy); end
      step();
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL init_no_rsp_enqueued got=%b exp=0", wr_en); end
      errs = errs;
   endtask

   task automatic test_alu();
      alu_wb_en = 1; alu_wb_addr = 5'd5; alu_wb_data = 32'hDEAD_BEEF;
      step();
      total++; if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL alu_write got=%b/%0d/%h exp=1/5/deadbeef", wr_en, wr_addr, wr_data); end
      alu_wb_addr = 5'd0; alu_wb_data = 32'h1111_2222;
      step();
      total++; if (wr_en !== 1'b0 || wr_addr !== 5'd5 || wr_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL alu_x0_drop got=%b/%0d/%h exp=0/5/deadbeef", wr_en, wr_addr, wr_data); end
      idle_inputs();
   endtask

   task automatic test_contention();
      ld_issue_en = 1; ld_issue_addr = 5'd7;
      step();
      ld_issue_en = 0;
      total++; if (busy[7] !== 1'b1) begin bad++; $display("FAIL cont_busy_set got=%b exp=1", busy[7]); end
      alu_wb_en = 1; alu_wb_addr = 5'd3; alu_wb_data = 32'hA0A0_0001;
      ld_rsp_valid = 1; ld_rsp_addr = 5'd7; ld_rsp_data = 32'h0000_1234;
      step();
      ld_rsp_valid = 0;
      total++; if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 32'hA0A0_0001 || busy[7] !== 1'b1) begin bad++; $display("FAIL cont_alu1 got=%b/%0d/%h busy7=%b exp=1/3/a0a00001 busy7=1", wr_en, wr_addr, wr_data, busy[7]); end
      alu_wb_data = 32'hA0A0_0002;
      step();
      total++; if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 32'hA0A0_0002 || busy[7] !== 1'b1) begin bad++; $display("FAIL cont_alu2 got=%b/%0d/%h busy7=%b exp=1/3/a0a00002 busy7=1", wr_en, wr_addr, wr_data, busy[7]); end
      alu_wb_en = 0;
      step();
      total++; if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'h0000_1234 || busy[7] !== 1'b0) begin bad++; $display("FAIL cont_load got=%b/%0d/%h busy7=%b exp=1/7/00001234 busy7=0", wr_en, wr_addr, wr_data, busy[7]); end
   endtask

   task automatic test_backpressure();
      logic [4:0]  ra[3];
      logic [31:0] rd[3];
      int          idx = 0;
      bit          acc;
      for (int i = 0; i < 3; i++) begin ra[i] = 5'(10 + i); rd[i] = $urandom; end
      alu_wb_en = 1; alu_wb_addr = 5'd4; alu_wb_data = $urandom;
      for (int c = 0; c < 7; c++) begin
         if (c == 3) alu_wb_en = 0;
         ld_rsp_valid = (idx < 3);
         if (idx < 3) begin ld_rsp_addr = ra[idx]; ld_rsp_data = rd[idx]; end
         acc = ld_rsp_valid && m_ready;
         step();
         if (acc) idx++;
         case (c)
            1, 2: begin
               total++; if (ld_rsp_ready !== 1'b0 || wr_addr !== 5'd4) begin bad++; $display("FAIL bp_full[%0d] got rdy=%b addr=%0d exp rdy=0 addr=4", c, ld_rsp_ready, wr_addr); end
            end
            3, 4, 5: begin
               total++; if (wr_en !== 1'b1 || wr_addr !== ra[c-3] || wr_data !== rd[c-3]) begin bad++; $display("FAIL bp_drain[%0d] got=%b/%0d/%h exp=1/%0d/%h", c-3, wr_en, wr_addr, wr_data, ra[c-3], rd[c-3]); end
               if (c == 3) begin
                  total++; if (ld_rsp_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_return got=%b exp=1", ld_rsp_ready); end
               end
            end
            6: begin
               total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", wr_en); end
            end
            default: ;
         endcase
      end
      idle_inputs();
   endtask

   task automatic test_collision();
      logic [31:0] busy_snap;
      ld_issue_en = 1; ld_issue_addr = 5'd9;
      step();
      ld_issue_en = 0;
      ld_rsp_valid = 1; ld_rsp_addr = 5'd9; ld_rsp_data = 32'h0000_0099;
      step();
      ld_rsp_valid = 0;
      ld_issue_en = 1; ld_issue_addr = 5'd9;
      step();
      ld_issue_en = 0;
      total++; if (wr_en !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 32'h99 || busy[9] !== 1'b1) begin bad++; $display("FAIL coll_set_wins got=%b/%0d/%h busy9=%b exp=1/9/99 busy9=1", wr_en, wr_addr, wr_data, busy[9]); end
      busy_snap = 32'h0000_0200;
      ld_rsp_valid = 1; ld_rsp_addr = 5'd0; ld_rsp_data = 32'hBAD0_BAD0;
      total++; if (ld_rsp_ready !== 1'b1) begin bad++; $display("FAIL x0_rsp_ready got=%b exp=1", ld_rsp_ready); end
      step();
      ld_rsp_valid = 0;
      total++; if (wr_en !== 1'b0 || busy !== busy_snap || ld_rsp_ready !== 1'b1) begin bad++; $display("FAIL x0_rsp_dropped got en=%b busy=%h rdy=%b exp en=0 busy=%h rdy=1", wr_en, busy, ld_rsp_ready, busy_snap); end
      step();
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL x0_rsp_never_written got=%b exp=0", wr_en); end
      // hand r9 back so later scenarios start from an idle scoreboard
      ld_rsp_valid = 1; ld_rsp_addr = 5'd9; ld_rsp_data = 32'h9;
      step();
      ld_rsp_valid = 0;
      step();
   endtask

   task automatic test_reset_mid();
      alu_wb_en = 1; alu_wb_addr = 5'd2; alu_wb_data = 32'hCAFE_0002;
      ld_issue_en = 1; ld_issue_addr = 5'd4; step();
      ld_issue_addr = 5'd7; step();
      ld_issue_en = 0;
      ld_rsp_valid = 1; ld_rsp_addr = 5'd4; ld_rsp_data = 32'h44; step();
      ld_rsp_addr = 5'd7; ld_rsp_data = 32'h77; step();
      ld_rsp_valid = 0;
      total++; if (busy !== 32'h0000_0090 || ld_rsp_ready !== 1'b0) begin bad++; $display("FAIL mid_setup got busy=%h rdy=%b exp busy=00000090 rdy=0", busy, ld_rsp_ready); end
      rst_n = 0;
      step();
      rst_n = 1;
      alu_wb_en = 0;
      total++; if (busy !== 32'd0 || init_done !== 1'b0 || ld_rsp_ready !== 1'b0 || wr_en !== 1'b0) begin bad++; $display("FAIL mid_reset got busy=%h done=%b rdy=%b en=%b exp 0/0/0/0", busy, init_done, ld_rsp_ready, wr_en); end
      for (int i = 0; i < 32; i++) begin
         step();
         total++;
         if (wr_en !== 1'b1 || wr_addr !== 5'(i) || wr_data !== 32'd0) begin bad++; $display("FAIL mid_sweep[%0d] got=%b/%0d/%h exp=1/%0d/0", i, wr_en, wr_addr, wr_data, i); end
      end
      step();
      total++; if (init_done !== 1'b1 || wr_en !== 1'b0) begin bad++; $display("FAIL mid_done got done=%b en=%b exp 1/0", init_done, wr_en); end
      step(); step();
      total++; if (wr_en !== 1'b0 || busy !== 32'd0) begin bad++; $display("FAIL mid_fifo_empty got en=%b busy=%h exp 0/0", wr_en, busy); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         rst_n         = ($urandom_range(0, 99) != 0);
         alu_wb_en     = ($urandom_range(0, 2) == 0);
         alu_wb_addr   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         alu_wb_data   = $urandom;
         ld_issue_en   = ($urandom_range(0, 2) == 0);
         ld_issue_addr = 5'($urandom_range(0, 11));
         ld_rsp_valid  = ($urandom_range(0, 1) == 0);
         ld_rsp_addr   = 5'($urandom_range(0, 11));
         ld_rsp_data   = $urandom;
         step();
         total++;
         if (wr_en !== m_wr_en || wr_addr !== m_wr_addr || wr_data !== m_wr_data) begin
            bad++; $display("FAIL rand_wr[%0d] got=%b/%0d/%h exp=%b/%0d/%h", c, wr_en, wr_addr, wr_data, m_wr_en, m_wr_addr, m_wr_data);
         end
         total++;
         if (busy !== m_busy || init_done !== m_done || ld_rsp_ready !== m_ready) begin
            bad++; $display("FAIL rand_state[%0d] got busy=%h done=%b rdy=%b exp busy=%h done=%b rdy=%b", c, busy, init_done, ld_rsp_ready, m_busy, m_done, m_ready);
         end
      end
      rst_n = 1;
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_init();
      test_alu();
      test_contention();
      test_backpressure();
      test_collision();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_ctrl.md
# wb_ctrl

Writeback controller driving the single write port of the 32x32 integer register file. It zero-initialises the whole register file after reset, because the file itself has no reset. It then arbitrates each cycle between the in-order ALU commit path and a buffered load-response stream. It also keeps a per-register busy scoreboard for outstanding loads, which decode uses for stall decisions.

## Interface
- WIDTH_ADDR, 5, register address width; register count NREG = 2**WIDTH_ADDR
- WIDTH_DATA, 32, register data width
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  synchronous active-low reset (sampled on posedge clk)
- alu_wb_en  in  1  ALU commit valid this cycle; always accepted, no ready
- alu_wb_addr  in  WIDTH_ADDR  ALU destination register
- alu_wb_data  in  WIDTH_DATA  ALU result
- ld_issue_en  in  1  load issued this cycle; marks destination busy
- ld_issue_addr  in  WIDTH_ADDR  issued load destination
- ld_rsp_valid  in  1  load response valid
- ld_rsp_ready  out  1  load response accepted when valid && ready
- ld_rsp_addr  in  WIDTH_ADDR  load response destination
- ld_rsp_data  in  WIDTH_DATA  load response data
- wr_en  out  1  register-file write enable (registered)
- wr_addr  out  WIDTH_ADDR  register-file write address (registered)
- wr_data  out  WIDTH_DATA  register-file write data (registered)
- busy  out  NREG  bit k = load to register k outstanding
- init_done  out  1  high once the zero sweep is complete

## Operation
- Reset (rst_n=0 at posedge):
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, init_done=0, ld_rsp_ready=0.
  - Load FIFO emptied. FSM enters INIT with sweep counter at 0.
- INIT:
  - Each cycle drive wr_en=1, wr_data=0, wr_addr=counter; counter increments.
  - After the write to address NREG-1, go to RUN.
  - In INIT, alu_wb_en, ld_issue_en and ld_rsp_valid are ignored, and ld_rsp_ready=0.
- RUN arbitration, evaluated once per cycle:
  1. If alu_wb_en && alu_wb_addr!=0, write the ALU data. The FIFO does not pop.
  2. Else, if the FIFO is non-empty, write the FIFO head and pop it.
  3. Else, wr_en=0. wr_addr and wr_data hold their previous values.
- x0 rule:
  - Register 0 is written only by INIT.
  - An ALU commit to 0 is dropped and does not block the FIFO that cycle.
  - A load response to 0 is accepted (handshake completes) but is not enqueued.
- Load FIFO:
  - 2 entries, each holding {addr, data}, in-order.
  - ld_rsp_ready = init_done && (count<2), computed from registered count.
  - An entry pushed in cycle N is not eligible to pop before cycle N+1.
  - Push and pop may occur in the same cycle.
- Scoreboard:
  - ld_issue_en with addr!=0 sets busy[addr].
  - A write sourced from the FIFO clears busy[addr].
  - ALU writes never touch busy.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - ld_issue_en to an already-busy register leaves it set. Decode must not issue this (WAW); it is not checked here.
- Reset asserted mid-operation: FIFO contents and busy bits are discarded and INIT restarts.

## Timing
- INIT duration:
  - wr_en is high for exactly NREG consecutive cycles (addr 0..NREG-1), starting the first cycle after rst_n is sampled high.
  - init_done rises in the cycle following the wr_addr=NREG-1 cycle and stays high until reset.
- ALU path latency: input sampled at edge N, so wr_* is valid in cycle N+1, one cycle.
- Load path latency with an empty FIFO and no ALU contention: accepted at edge N, popped at edge N+1, wr_* valid in cycle N+2. Each ALU commit in between adds one cycle.
- busy timing:
  - busy[k] rises in the cycle after the ld_issue_en edge.
  - busy[k] falls in the same cycle that wr_en/wr_addr=k (load source) is presented.
- Throughput: at most one register write per cycle. A sustained ALU stream (addr!=0) starves the FIFO, and ld_rsp_ready stays low once the FIFO is full.

## Test plan
- Init sweep: release reset, then wr_en=1 for 32 cycles with addr 0..31 and data 0. init_done=1 on cycle 33; ld_rsp_ready=1 the same cycle.
- ALU write: alu_wb_en, addr=5, data=0xDEADBEEF. Next cycle: wr_en=1, wr_addr=5, wr_data=0xDEADBEEF. An ALU write with addr=0 produces wr_en=0.
- Load with contention:
  - Issue a load to r7, so busy[7]=1.
  - Send a response (r7, 0x1234) together with an ALU commit to r3 for 2 cycles.
  - Expected: r3 is written twice, then r7=0x1234. busy[7] clears in the same cycle r7 is written.
- Backpressure:
  - Hold ALU commits continuously and present 3 load responses.
  - Expected: the first 2 are accepted, then ld_rsp_ready=0. Drop the ALU commits, and the responses write in order, one per cycle; ready returns high after the first pop.
- Scoreboard collision: a FIFO write to r9 in the same cycle as a new ld_issue to r9 leaves busy[9]=1. A load response to r0 is handshaked, never written, and busy is unchanged.
- Reset mid-run: with 2 FIFO entries and busy=0x0000_0090, assert rst_n=0 for 1 cycle. Expected: busy=0, FIFO empty, and the full 32-cycle INIT sweep repeats.
